// File: rtl/alu_pkg.sv
// Shared command encodings and FSM state type for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: WIDTH iterations after start; done/product are valid during the last one.
// Backpressure: none; the caller only starts it when it can take the result.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_nxt;

    // Partial sum for this iteration; on the last one it is the final product.
    always_comb begin
        acc_nxt = mplier[0] ? (acc + mcand) : acc;
    end

    assign done    = busy && (cnt == LAST);
    assign product = acc_nxt;

    // Operand capture on start, then one shift-add step per cycle until the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an iterative multiply.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL (result in cycle WIDTH+1).
// Backpressure: valid/ready; a stalled result holds and blocks new requests, transfer+accept may overlap.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             V,
    output logic             N,
    output logic             Z
);

    state_t           state;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] res;
    logic             c_res;
    logic             v_res;
    logic             is_add;
    logic             is_sub;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (MUL_EN != 0) && (command == CMD_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (input1),
        .b       (input2),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle datapath; arithmetic runs zero-extended so bit WIDTH is the carry/borrow.
    always_comb begin
        arith  = '0;
        res    = '0;
        c_res  = 1'b0;
        v_res  = 1'b0;
        is_add = 1'b0;
        is_sub = 1'b0;
        case (command)
            CMD_MOV: res = input2;
            CMD_MVN: res = ~input2;
            CMD_ADD: begin
                arith  = {1'b0, input1} + {1'b0, input2};
                is_add = 1'b1;
            end
            CMD_ADC: begin
                arith  = {1'b0, input1} + {1'b0, input2} + {{WIDTH{1'b0}}, carry_in};
                is_add = 1'b1;
            end
            CMD_SUB: begin
                arith  = {1'b0, input1} - {1'b0, input2};
                is_sub = 1'b1;
            end
            CMD_SBC: begin
                arith  = {1'b0, input1} - {1'b0, input2} - (WIDTH+1)'(1)
                         + {{WIDTH{1'b0}}, carry_in};
                is_sub = 1'b1;
            end
            CMD_AND: res = input1 & input2;
            CMD_ORR: res = input1 | input2;
            CMD_EOR: res = input1 ^ input2;
            default: res = '0;
        endcase
        if (is_add || is_sub) begin
            res   = arith[WIDTH-1:0];
            c_res = arith[WIDTH];
        end
        if (is_add) begin
            v_res = (input1[WIDTH-1] == input2[WIDTH-1]) && (res[WIDTH-1] != input1[WIDTH-1]);
        end else if (is_sub) begin
            v_res = (input1[WIDTH-1] != input2[WIDTH-1]) && (res[WIDTH-1] != input1[WIDTH-1]);
        end
    end

    // Control FSM and registered result/flags; a transfer clears out_valid unless a new result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            V         <= 1'b0;
            N         <= 1'b0;
            Z         <= 1'b1;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MUL;
                        end else begin
                            out       <= res;
                            carry_out <= c_res;
                            V         <= v_res;
                            N         <= res[WIDTH-1];
                            Z         <= (res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        out       <= mul_prod;
                        carry_out <= 1'b0;
                        V         <= 1'b0;
                        N         <= mul_prod[WIDTH-1];
                        Z         <= (mul_prod == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32), with a second MUL_EN=0 build alongside.
// Latency: checks 1-cycle ops and the 33-cycle multiply result timing.
// Backpressure: exercises stalled results, overlapped transfer/accept and reset mid-multiply.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [3:0]   command = 4'h0;
    logic [W-1:0] input1 = '0;
    logic [W-1:0] input2 = '0;
    logic         carry_in = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready, out_valid, carry_out, V, N, Z;
    logic [W-1:0] out;
    logic         in_ready_u, out_valid_u, carry_out_u, V_u, N_u, Z_u;
    logic [W-1:0] out_u;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .command(command), .input1(input1), .input2(input2), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .carry_out(carry_out), .V(V), .N(N), .Z(Z)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .command(command), .input1(input1), .input2(input2), .carry_in(carry_in),
        .out_valid(out_valid_u), .out_ready(out_ready), .out(out_u),
        .carry_out(carry_out_u), .V(V_u), .N(N_u), .Z(Z_u)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Check result and flags of either build (u=1 selects the MUL_EN=0 instance).
    task automatic chk_res(input string tag, input bit u, input logic [W-1:0] e_out,
                           input logic e_c, input logic e_v, input logic e_n, input logic e_z);
        chk({tag, ".vld"}, 64'(u ? out_valid_u : out_valid), 64'd1);
        chk({tag, ".out"}, 64'(u ? out_u : out), 64'(e_out));
        chk({tag, ".c"},   64'(u ? carry_out_u : carry_out), 64'(e_c));
        chk({tag, ".v"},   64'(u ? V_u : V), 64'(e_v));
        chk({tag, ".n"},   64'(u ? N_u : N), 64'(e_n));
        chk({tag, ".z"},   64'(u ? Z_u : Z), 64'(e_z));
    endtask

    // Present one request at the falling edge; returns #1 after the accepting rising edge.
    task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        @(negedge clk);
        command  = cmd;
        input1   = a;
        input2   = b;
        carry_in = cin;
        in_valid = 1'b1;
        chk("issue.rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int low;
        int stale;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld", 64'(out_valid), 64'd0);
        chk("rst.out", 64'(out), 64'd0);
        chk("rst.c", 64'(carry_out), 64'd0);
        chk("rst.v", 64'(V), 64'd0);
        chk("rst.n", 64'(N), 64'd0);
        chk("rst.z", 64'(Z), 64'd1);
        chk("rst.rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle arithmetic, result visible one cycle after acceptance
        issue(CMD_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk_res("add_ovf", 0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("vld_drop", 64'(out_valid), 64'd0);

        issue(CMD_SUB, 32'd5, 32'd5, 1'b0);
        chk_res("sub_eq", 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(CMD_SBC, 32'd5, 32'd3, 1'b0);
        chk_res("sbc", 0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(CMD_SUB, 32'd3, 32'd5, 1'b0);
        chk_res("sub_borrow", 0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        issue(CMD_ADC, 32'hFFFF_FFFF, 32'd0, 1'b1);
        chk_res("adc_wrap", 0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(CMD_SUB, 32'h8000_0000, 32'd1, 1'b0);
        chk_res("sub_ovf", 0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(CMD_MVN, 32'h1234_5678, 32'd0, 1'b1);
        chk_res("mvn", 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(CMD_MOV, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        chk_res("mov", 0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);

        // Multiply: operands changed after acceptance must not matter
        issue(CMD_MUL, 32'h0001_0001, 32'h0001_0001, 1'b0);
        input1 = 32'hFFFF_FFFF;
        input2 = 32'hFFFF_FFFF;
        lat = 1;
        low = 0;
        while (!out_valid && lat <= 200) begin
            if (!in_ready) low++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul.lat", 64'(lat), 64'd33);
        chk("mul.rdy_low", 64'(low), 64'd32);
        chk_res("mul", 0, 32'h0002_0001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back logic ops, then a 4-cycle stall with a request waiting
        @(negedge clk);
        input1   = 32'hF0F0_1234;
        input2   = 32'h0FF0_FF00;
        command  = CMD_AND;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_res("b2b_and", 0, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 1'b0);
        command = CMD_ORR;
        @(posedge clk);
        #1;
        chk_res("b2b_orr", 0, 32'hFFF0_FF34, 1'b0, 1'b0, 1'b1, 1'b0);
        command = CMD_EOR;
        @(posedge clk);
        #1;
        chk_res("b2b_eor", 0, 32'hFF00_ED34, 1'b0, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        command   = CMD_ADD;
        input1    = 32'd2;
        input2    = 32'd3;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk_res("bp_hold", 0, 32'hFF00_ED34, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_hold.rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel.rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_res("bp_next", 0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a multiply
        issue(CMD_MUL, 32'd3, 32'd4, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mulrst.vld", 64'(out_valid), 64'd0);
        chk("mulrst.out", 64'(out), 64'd0);
        chk("mulrst.z", 64'(Z), 64'd1);
        chk("mulrst.rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        chk("mulrst.stale", 64'(stale), 64'd0);
        issue(CMD_ADD, 32'd2, 32'd3, 1'b0);
        chk_res("post_rst_add", 0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Undefined command on both builds
        issue(4'b1111, 32'd12, 32'd34, 1'b1);
        chk_res("undef", 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_res("undef_u", 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // MUL on the MUL_EN=0 build behaves as undefined; the full build still multiplies
        issue(CMD_ADD, 32'd2, 32'd3, 1'b0);
        chk_res("pre_u", 1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(CMD_MUL, 32'd7, 32'd9, 1'b0);
        chk_res("mul_u", 1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        lat = 1;
        while (!out_valid && lat <= 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul2.lat", 64'(lat), 64'd33);
        chk_res("mul2", 0, 32'd63, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
